// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, HALT encoding and fetch-state type for the IF stage
package if_stage_pkg;
  localparam int PC_BITS = 32;
  localparam int INSTRUCTION_BITS = 32;
  localparam int REG_ADDRS_BITS = 5;
  localparam int IMEM_ADDR_BITS = 8;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [INSTRUCTION_BITS-1:0] INSTRUCTION_NOP = '0;
  typedef enum logic {RUN, HALTED} state_t;
endpackage

// File: rtl/if_stage_instruction_memory.sv
// if_stage_instruction_memory: word array, synchronous write, asynchronous read, no reset
module if_stage_instruction_memory
  import if_stage_pkg::*;
#(
  parameter int ADDR_BITS = IMEM_ADDR_BITS,
  parameter int DATA_BITS = INSTRUCTION_BITS
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, instruction fetch, IF/ID register and HALT freeze for the 5-stage MIPS pipeline
module if_stage
  import if_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_PCWrite,
  input  logic                        i_if_id_write,
  input  logic                        i_pc_src,
  input  logic [PC_BITS-1:0]          i_branch_target,
  input  logic                        i_flush,
  input  logic                        i_imem_wr_en,
  input  logic [IMEM_ADDR_BITS-1:0]   i_imem_wr_addr,
  input  logic [INSTRUCTION_BITS-1:0] i_imem_wr_data,
  output logic [INSTRUCTION_BITS-1:0] o_instruction,
  output logic [PC_BITS-1:0]          o_pc_plus4,
  output logic [2*REG_ADDRS_BITS-1:0] o_instruction_rs_rt,
  output logic [PC_BITS-1:0]          o_pc,
  output logic                        o_halted
);
  state_t state, state_next;
  logic [PC_BITS-1:0] pc, pc_plus4, pc_next;
  logic [INSTRUCTION_BITS-1:0] fetched;
  logic halted, halt_take, resume, squash, ifid_load;

  if_stage_instruction_memory u_imem (
    .clk     (clk),
    .wr_en   (i_imem_wr_en),
    .wr_addr (i_imem_wr_addr),
    .wr_data (i_imem_wr_data),
    .rd_addr (pc[IMEM_ADDR_BITS+1:2]),
    .rd_data (fetched)
  );

  // HALT is taken only when it actually enters IF/ID; while halted, NOPs drain behind it
  always_comb begin
    halted     = state == HALTED;
    pc_plus4   = pc + PC_BITS'(4);
    halt_take  = !halted && fetched[31:26] == HALT_OPCODE && i_if_id_write && !i_flush && !i_pc_src;
    resume     = halted && i_flush && i_pc_src;
    squash     = i_flush || halted;
    ifid_load  = squash || i_if_id_write;
    pc_next    = (i_pc_src && (!halted || i_flush)) ? i_branch_target :
                 (halted || !i_PCWrite || halt_take) ? pc : pc_plus4;
    state_next = halt_take ? HALTED : resume ? RUN : state;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc            <= '0;
      state         <= RUN;
      o_instruction <= INSTRUCTION_NOP;
      o_pc_plus4    <= '0;
    end else if (i_enable) begin
      pc    <= pc_next;
      state <= state_next;
      if (ifid_load) begin
        o_instruction <= squash ? INSTRUCTION_NOP : fetched;
        o_pc_plus4    <= squash ? '0 : pc_plus4;
      end
    end

  assign o_pc                = pc;
  assign o_halted            = halted;
  assign o_instruction_rs_rt = o_instruction[25:16];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector self-checking bench for if_stage
module tb_if_stage;
  logic clk = 0, rst = 1;
  logic enable = 0, pc_write = 1, if_id_write = 1, pc_src = 0, flush = 0;
  logic [31:0] branch_target = 0;
  logic wr_en = 0;
  logic [7:0] wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] instruction, pc_plus4, pc;
  logic [9:0] rs_rt;
  logic halted;
  int checks = 0, errors = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_PCWrite(pc_write),
    .i_if_id_write(if_id_write), .i_pc_src(pc_src), .i_branch_target(branch_target),
    .i_flush(flush), .i_imem_wr_en(wr_en), .i_imem_wr_addr(wr_addr),
    .i_imem_wr_data(wr_data), .o_instruction(instruction), .o_pc_plus4(pc_plus4),
    .o_instruction_rs_rt(rs_rt), .o_pc(pc), .o_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] e_instr, input logic [31:0] e_p4,
                           input logic [31:0] e_pc, input logic e_halt);
    check({tag, ".instr"}, instruction, e_instr);
    check({tag, ".pc4"}, pc_plus4, e_p4);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halt});
  endtask

  initial begin
    @(negedge clk);
    write_word(8'd0, 32'h20010005);
    write_word(8'd1, 32'h20020007);
    write_word(8'd2, 32'h00221820);
    write_word(8'd3, 32'hFC000000);
    write_word(8'd8, 32'h11111111);
    write_word(8'd9, 32'h22222222);
    write_word(8'd16, 32'h33333333);
    write_word(8'd17, 32'h44444444);
    write_word(8'd18, 32'h77777777);
    write_word(8'd19, 32'hFC000000);
    write_word(8'd255, 32'h12345678);
    expect_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    rst = 0; enable = 1;
    tick(); expect_if("seq0", 32'h20010005, 32'd4, 32'd4, 1'b0);
    tick(); expect_if("seq1", 32'h20020007, 32'd8, 32'd8, 1'b0);
    pc_write = 0; if_id_write = 0;
    tick(); expect_if("stall", 32'h20020007, 32'd8, 32'd8, 1'b0);
    pc_write = 1; if_id_write = 1;
    tick(); expect_if("seq2", 32'h00221820, 32'd12, 32'd12, 1'b0);
    check("rs_rt", {22'b0, rs_rt}, {22'b0, 5'd1, 5'd2});

    tick(); expect_if("halt", 32'hFC000000, 32'd16, 32'd12, 1'b1);
    tick(); expect_if("drain0", 32'h0, 32'h0, 32'd12, 1'b1);
    flush = 1;
    tick(); expect_if("flush_no_src", 32'h0, 32'h0, 32'd12, 1'b1);
    pc_src = 1; branch_target = 32'h20;
    tick(); expect_if("unhalt", 32'h0, 32'h0, 32'h20, 1'b0);
    pc_src = 0; flush = 0;
    tick(); expect_if("after_unhalt", 32'h11111111, 32'h24, 32'h24, 1'b0);

    pc_src = 1; flush = 1; branch_target = 32'h40; pc_write = 0; if_id_write = 0;
    tick(); expect_if("redirect_stall", 32'h0, 32'h0, 32'h40, 1'b0);
    pc_src = 0; flush = 0; pc_write = 1; if_id_write = 1;

    enable = 0;
    write_word(8'd16, 32'h55555555);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_if("disabled", 32'h0, 32'h0, 32'h40, 1'b0);
    end
    enable = 1;
    tick(); expect_if("reenable", 32'h55555555, 32'h44, 32'h44, 1'b0);
    wr_en = 1; wr_addr = 8'd17; wr_data = 32'h66666666;
    tick(); wr_en = 0;
    expect_if("write_same_cycle", 32'h44444444, 32'h48, 32'h48, 1'b0);

    tick(); expect_if("pre_halt2", 32'h77777777, 32'h4C, 32'h4C, 1'b0);
    pc_write = 0; if_id_write = 0;
    tick(); expect_if("halt_stalled", 32'h77777777, 32'h4C, 32'h4C, 1'b0);
    pc_write = 1; if_id_write = 1;
    tick(); expect_if("halt2", 32'hFC000000, 32'h50, 32'h4C, 1'b1);
    tick(); expect_if("drain2", 32'h0, 32'h0, 32'h4C, 1'b1);

    #2 rst = 1;
    #1 expect_if("async_rst_halted", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); rst = 0;
    tick(); expect_if("mem_kept", 32'h20010005, 32'd4, 32'd4, 1'b0);
    pc_write = 0; if_id_write = 0;
    tick(); expect_if("stall2", 32'h20010005, 32'd4, 32'd4, 1'b0);
    #2 rst = 1;
    #1 expect_if("async_rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); rst = 0; pc_write = 1; if_id_write = 1;
    tick(); expect_if("post_rst", 32'h20010005, 32'd4, 32'd4, 1'b0);

    pc_src = 1; flush = 1; branch_target = 32'h400;
    tick(); expect_if("alias_jump", 32'h0, 32'h0, 32'h400, 1'b0);
    pc_src = 0; flush = 0;
    tick(); expect_if("alias_fetch", 32'h20010005, 32'h404, 32'h404, 1'b0);
    pc_src = 1; flush = 1; branch_target = 32'hFFFFFFFC;
    tick(); expect_if("wrap_jump", 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0);
    pc_src = 0; flush = 0;
    tick(); expect_if("wrap_fetch", 32'h12345678, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: program counter, internal instruction memory and the IF/ID pipeline register.
- Directly upstream of decode and of the hazard detector.
- Consumes the hazard detector's PC-write and IF/ID-write enables.
- Consumes branch/jump redirects and flushes from later stages.
- Detects the HALT instruction and freezes fetch.
- Instruction memory is loaded by the debug unit through a write port while the pipeline is disabled.

Parameters:
PC_BITS, 32, program counter width (byte address)
INSTRUCTION_BITS, 32, instruction width
REG_ADDRS_BITS, 5, register address width (rs/rt fields)
IMEM_ADDR_BITS, 8, instruction memory word-address width (256 words)
HALT_OPCODE, 6'b111111, opcode field value marking HALT

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous active-high reset
i_enable  in  1  pipeline step enable from the debug unit; 0 freezes all stage state
i_PCWrite  in  1  hazard detector: 0 = hold PC (load-use stall)
i_if_id_write  in  1  hazard detector: 0 = hold the IF/ID register
i_pc_src  in  1  1 = redirect PC to i_branch_target this cycle
i_branch_target  in  PC_BITS  redirect address (taken branch/jump)
i_flush  in  1  1 = load NOP into IF/ID (squash the wrong-path fetch)
i_imem_wr_en  in  1  instruction memory write strobe
i_imem_wr_addr  in  IMEM_ADDR_BITS  word address to write
i_imem_wr_data  in  INSTRUCTION_BITS  word to write
o_instruction  out  INSTRUCTION_BITS  IF/ID instruction
o_pc_plus4  out  PC_BITS  IF/ID PC+4 of that instruction
o_instruction_rs_rt  out  2*REG_ADDRS_BITS  {rs, rt} = o_instruction[25:16], rs in the upper half; feeds the hazard detector
o_pc  out  PC_BITS  current PC (debug readout)
o_halted  out  1  1 = HALT fetched and fetch frozen

Behaviour:
- Reset (async, any time, including mid-stall or while halted):
  - PC=0, o_instruction=0 (NOP), o_pc_plus4=0.
  - State RUN, o_halted=0.
  - Memory contents are not cleared.
- Fetch path:
  - fetched = imem[PC[IMEM_ADDR_BITS+1:2]], combinational read. PC bits above that range are ignored (address aliasing).
  - PC+4 wraps modulo 2^PC_BITS.
- i_enable=0: PC, IF/ID register and state all hold. Memory writes still occur.
- State RUN, i_enable=1, PC next-value priority:
  1. i_pc_src=1 -> i_branch_target; the redirect overrides a concurrent stall.
  2. i_PCWrite=0 -> hold.
  3. Otherwise -> PC+4.
- IF/ID next-value priority:
  1. i_flush=1 -> instruction 0 and pc_plus4 0; the flush overrides i_if_id_write=0.
  2. i_if_id_write=0 -> hold.
  3. Otherwise -> fetched instruction and PC+4.
- HALT detection (RUN):
  - Trigger: fetched[31:26]==HALT_OPCODE and it is being latched (i_if_id_write=1, i_flush=0, i_pc_src=0).
  - The HALT word enters IF/ID and the state goes to HALTED next edge.
  - PC is held at the HALT address (not advanced).
- State HALTED, i_enable=1:
  - o_halted=1, PC holds, IF/ID loads NOP each edge so HALT drains alone.
  - i_flush=1 with i_pc_src=1 (older branch taken) -> state RUN, PC = i_branch_target, IF/ID = NOP, o_halted=0 on the next edge.
  - i_flush without i_pc_src -> stays HALTED.
- Stall without flush while HALT is fetched: not latched, no transition until the write enable returns.
- Memory write: occurs at the rising edge when i_imem_wr_en=1. A fetch of the same word in that cycle returns the old data; the new data is visible the following cycle.
- Latency: instruction at PC appears on o_instruction one edge after fetch; o_instruction_rs_rt is purely combinational from the register.

Decomposition:
- constants.vh gains PC_BITS, IMEM_ADDR_BITS, HALT_OPCODE and INSTRUCTION_NOP (32'b0); it reuses INSTRUCTION_BITS and REG_ADDRS_BITS.
- One sub-module, instruction_memory:
  - register array with a synchronous write port and an asynchronous read port;
  - no reset.
- PC, IF/ID and the RUN/HALTED state stay in if_stage.

Test Plan:
- Load 0x20010005, 0x20020007, 0x00221820 at words 0-2, release rst, enable:
  - o_instruction shows the three words on consecutive edges;
  - o_pc_plus4 = 4, 8, 12;
  - o_instruction_rs_rt for 0x00221820 = {5'd1, 5'd2}.
- Assert i_PCWrite=0 and i_if_id_write=0 for 1 cycle at PC=8: PC stays 8, o_instruction holds, then sequential fetch resumes.
- At PC=8 drive i_pc_src=1, i_branch_target=0x40, i_flush=1 together with i_PCWrite=0: next edge PC=0x40 and o_instruction=0.
- Place 0xFC000000 at word 3:
  - o_instruction=0xFC000000, then NOP every following edge;
  - o_pc=12 constant, o_halted=1;
  - later i_pc_src=1/i_flush=1 to 0x20 -> o_halted=0, PC=0x20.
- Deassert i_enable for 5 cycles mid-stream: o_pc/o_instruction unchanged. A concurrent imem write to the current PC word is seen only after re-enable.
- Assert rst asynchronously while HALTED and mid-stall: outputs go to PC=0, NOP, o_halted=0 without a clock edge, and memory contents are preserved.
